// File: rtl/riscv_wb_collect.sv
// Write-back collector: merges ALU/MUL/DIV results into one in-order stream.
// A small FIFO holds results while the register-file port is stalled.
module riscv_wb_collect #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            alu_bubble,
    input  logic [XLEN-1:0] alu_r,
    input  logic            mul_bubble,
    input  logic [XLEN-1:0] mul_r,
    input  logic            div_bubble,
    input  logic [XLEN-1:0] div_r,
    input  logic [4:0]      ex_rd,
    input  logic            wb_stall,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_r,
    output logic            wb_full,
    output logic            wb_conflict,
    output logic            wb_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] r;
    } wb_entry_t;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rptr, wptr;
    logic [CW-1:0]   count, count_nxt;

    logic            in_valid, multi, enq, deq, push, is_full;
    logic [XLEN-1:0] sel_r;
    wb_entry_t       head;

    always_comb begin
        in_valid = ~div_bubble | ~mul_bubble | ~alu_bubble;
        multi    = (~div_bubble & ~mul_bubble) | (~div_bubble & ~alu_bubble) |
                   (~mul_bubble & ~alu_bubble);
        if (!div_bubble)      sel_r = div_r;
        else if (!mul_bubble) sel_r = mul_r;
        else                  sel_r = alu_r;
    end

    assign is_full = (count == CW'(DEPTH));
    assign enq     = in_valid && (ex_rd != 5'd0);
    assign deq     = wb_we && !wb_stall;
    // At full, a same-cycle dequeue frees the slot the new entry takes.
    assign push    = enq && (!is_full || deq);

    always_comb begin
        count_nxt = count;
        case ({push, deq})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            wb_full     <= 1'b0;
            wb_conflict <= 1'b0;
            wb_overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (deq)  rptr <= rptr + AW'(1);
            count       <= count_nxt;
            // Raised one entry early so the in-flight result still fits.
            wb_full     <= (count_nxt >= CW'(DEPTH - 1));
            wb_conflict <= multi;
            wb_overflow <= wb_overflow | (enq & is_full & ~deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) mem[wptr] <= '{rd: ex_rd, r: sel_r};
    end

    assign head  = mem[rptr];
    assign wb_we = (count != '0);
    assign wb_rd = wb_we ? head.rd : 5'd0;
    assign wb_r  = wb_we ? head.r  : '0;

endmodule
